// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - request, memory bus and tag return signals of the memory bus arbiter
interface mem_bus_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int TAG_W  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [NUM_CH*2-1:0]      req_cmd;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        grant;
    logic [NUM_CH*TAG_W-1:0]  ch_response;
    logic [NUM_CH-1:0]        ch_tag_valid;
    logic [TAG_W-1:0]         ch_tag;
    logic [DATA_W-1:0]        ch_data;
    logic [1:0]               proc2mem_command;
    logic [ADDR_W-1:0]        proc2mem_addr;
    logic [DATA_W-1:0]        proc2mem_data;
    logic [TAG_W-1:0]         mem2proc_response;
    logic [DATA_W-1:0]        mem2proc_data;
    logic [TAG_W-1:0]         mem2proc_tag;
    logic                     orphan_err;
    logic                     dup_err;

    modport slave (
        input  req_cmd, req_addr, req_data, mem2proc_response, mem2proc_data, mem2proc_tag,
        output grant, ch_response, ch_tag_valid, ch_tag, ch_data,
               proc2mem_command, proc2mem_addr, proc2mem_data, orphan_err, dup_err
    );

    modport master (
        output req_cmd, req_addr, req_data, mem2proc_response, mem2proc_data, mem2proc_tag,
        input  grant, ch_response, ch_tag_valid, ch_tag, ch_data,
               proc2mem_command, proc2mem_addr, proc2mem_data, orphan_err, dup_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin NUM_CH-way memory bus arbiter with load tag ownership routing
// Optional per-channel grant/stall counters are enabled with MEM_ARB_PERF_CNT_EN.
module mem_bus_arbiter #(
    parameter int NUM_CH = 2,
    parameter int TAG_W  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    mem_bus_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [NUM_CH*32-1:0] grant_cnt,
    output logic [NUM_CH*32-1:0] stall_cnt
`endif
);
    localparam int         PTR_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int         NUM_TAGS  = 1 << TAG_W;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_TAGS-1:0] own_vld_q;
    logic [PTR_W-1:0]    own_idx_q [NUM_TAGS];
    logic                orphan_err_q, dup_err_q;

    logic [NUM_CH-1:0]   req_vld, gnt;
    logic                gnt_any, accept, accept_load, ret_hit;
    logic [PTR_W-1:0]    gnt_idx;
    logic [1:0]          gnt_cmd;
    logic [TAG_W-1:0]    resp, ret_tag;

    assign resp    = bus.mem2proc_response;
    assign ret_tag = bus.mem2proc_tag;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            req_vld[i] = (bus.req_cmd[2*i +: 2] == BUS_LOAD) || (bus.req_cmd[2*i +: 2] == BUS_STORE);
        end
    end

    // First requester at or after rr_ptr, wrapping; reset suppresses any grant.
    always_comb begin : rr_search
        int c;
        c       = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (int'(rr_ptr_q) + k) % NUM_CH;
            if (!gnt_any && req_vld[c]) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'(c);
            end
        end
        if (reset) gnt_any = 1'b0;
        gnt = '0;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    assign gnt_cmd     = bus.req_cmd[2*int'(gnt_idx) +: 2];
    assign accept      = gnt_any && (resp != '0);
    assign accept_load = accept && (gnt_cmd == BUS_LOAD);
    assign ret_hit     = (ret_tag != '0) && own_vld_q[ret_tag];
    assign rr_ptr_d    = accept ? PTR_W'((int'(gnt_idx) + 1) % NUM_CH) : rr_ptr_q;

    always_comb begin
        bus.grant            = gnt;
        bus.ch_response      = '0;
        bus.ch_tag_valid     = '0;
        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        if (gnt_any) begin
            bus.ch_response[TAG_W*int'(gnt_idx) +: TAG_W] = resp;
            bus.proc2mem_command = gnt_cmd;
            bus.proc2mem_addr    = bus.req_addr[ADDR_W*int'(gnt_idx) +: ADDR_W];
            bus.proc2mem_data    = bus.req_data[DATA_W*int'(gnt_idx) +: DATA_W];
        end
        if (ret_hit && !reset) bus.ch_tag_valid[own_idx_q[ret_tag]] = 1'b1;
        bus.ch_tag     = ret_tag;
        bus.ch_data    = bus.mem2proc_data;
        bus.orphan_err = orphan_err_q;
        bus.dup_err    = dup_err_q;
    end

    // Return clears before allocation sets, so a same-cycle re-allocation of the tag wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            own_vld_q    <= '0;
            orphan_err_q <= 1'b0;
            dup_err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (ret_tag != '0) begin
                if (ret_hit) own_vld_q[ret_tag] <= 1'b0;
                else         orphan_err_q       <= 1'b1;
            end
            if (accept_load) begin
                own_vld_q[resp] <= 1'b1;
                if (own_vld_q[resp] && (resp != ret_tag)) dup_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept_load && !reset) own_idx_q[resp] <= gnt_idx;
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] grant_cnt_q [NUM_CH];
    logic [31:0] stall_cnt_q [NUM_CH];

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset) begin
                grant_cnt_q[i] <= '0;
                stall_cnt_q[i] <= '0;
            end else begin
                if (accept && (int'(gnt_idx) == i) && (grant_cnt_q[i] != '1))
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                if (req_vld[i] && !(accept && (int'(gnt_idx) == i)) && (stall_cnt_q[i] != '1))
                    stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            grant_cnt[32*i +: 32] = grant_cnt_q[i];
            stall_cnt[32*i +: 32] = stall_cnt_q[i];
        end
    end
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and randomized bench for mem_bus_arbiter against a tag-ownership model
module tb_mem_bus_arbiter;
    localparam int NUM_CH   = 2;
    localparam int TAG_W    = 4;
    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int NUM_TAGS = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    mem_bus_arbiter_if #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic [NUM_CH*32-1:0] grant_cnt, stall_cnt;
`endif

    mem_bus_arbiter #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .grant_cnt(grant_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: round-robin pointer, tag -> owner map (-1 = free), sticky flags.
    int m_rr;
    int m_own [NUM_TAGS];
    bit m_orphan, m_dup;
    int e_win;
    logic [NUM_CH-1:0]       e_grant, e_tv;
    logic [NUM_CH*TAG_W-1:0] e_resp;
    logic [1:0]              e_cmd;
    logic [63:0]             e_addr, e_data;

    function automatic void model_eval();
        e_win = -1;
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                int c;
                logic [1:0] cmd;
                c   = (m_rr + k) % NUM_CH;
                cmd = bus.req_cmd[2*c +: 2];
                if (e_win < 0 && (cmd == 2'd1 || cmd == 2'd2)) e_win = c;
            end
        end
        e_grant = '0; e_resp = '0; e_tv = '0; e_cmd = 2'd0; e_addr = '0; e_data = '0;
        if (e_win >= 0) begin
            e_grant[e_win] = 1'b1;
            e_resp[TAG_W*e_win +: TAG_W] = bus.mem2proc_response;
            e_cmd  = bus.req_cmd[2*e_win +: 2];
            e_addr = bus.req_addr[64*e_win +: 64];
            e_data = bus.req_data[64*e_win +: 64];
        end
        if (!reset && bus.mem2proc_tag != 0 && m_own[bus.mem2proc_tag] >= 0)
            e_tv[m_own[bus.mem2proc_tag]] = 1'b1;
    endfunction

    function automatic void model_commit();
        int resp, tag;
        resp = int'(bus.mem2proc_response);
        tag  = int'(bus.mem2proc_tag);
        if (reset) begin
            m_rr = 0; m_orphan = 0; m_dup = 0;
            foreach (m_own[t]) m_own[t] = -1;
            return;
        end
        if (tag != 0) begin
            if (m_own[tag] >= 0) m_own[tag] = -1;
            else                 m_orphan = 1;
        end
        if (e_win >= 0 && resp != 0) begin
            if (bus.req_cmd[2*e_win +: 2] == 2'd1) begin
                if (m_own[resp] >= 0) m_dup = 1;
                m_own[resp] = e_win;
            end
            m_rr = (e_win + 1) % NUM_CH;
        end
    endfunction

    task automatic tick();
        model_eval();
        @(posedge clock);
        model_commit();
        #1;
    endtask

    task automatic drive(input logic [1:0] c0, input logic [1:0] c1, input logic [TAG_W-1:0] resp,
                         input logic [TAG_W-1:0] tag, input logic [63:0] mdata);
        bus.req_cmd           = {c1, c0};
        bus.req_addr          = {64'h0000_0000_0000_1000, 64'h0000_0000_0000_0A00};
        bus.req_data          = {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        bus.mem2proc_response = resp;
        bus.mem2proc_tag      = tag;
        bus.mem2proc_data     = mdata;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(2'd0, 2'd0, 4'd0, 4'd0, 64'd0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(2'd1, 2'd2, 4'd5, 4'd3, 64'h55);
        tick();
        checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b want 00", bus.grant); end
        checks++; if (bus.ch_response !== 8'h00) begin errors++; $display("FAIL rst_ch_response got %h want 00", bus.ch_response); end
        checks++; if (bus.ch_tag_valid !== 2'b00) begin errors++; $display("FAIL rst_tag_valid got %b want 00", bus.ch_tag_valid); end
        checks++; if (bus.proc2mem_command !== 2'd0) begin errors++; $display("FAIL rst_command got %0d want 0", bus.proc2mem_command); end
        checks++; if (bus.proc2mem_addr !== 64'd0 || bus.proc2mem_data !== 64'd0) begin errors++; $display("FAIL rst_addr_data got %h/%h want 0/0", bus.proc2mem_addr, bus.proc2mem_data); end
        checks++; if (bus.orphan_err !== 1'b0 || bus.dup_err !== 1'b0) begin errors++; $display("FAIL rst_errs got %b%b want 00", bus.orphan_err, bus.dup_err); end
        reset = 1'b0;
        drive(2'd1, 2'd1, 4'd0, 4'd0, 64'd0);
        checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL rst_first_grant got %b want 01", bus.grant); end
        tick();
    endtask

    task automatic test_alternate();
        do_reset();
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive(2'd1, 2'd1, (cyc % 2) ? 4'd6 : 4'd5, 4'd0, 64'd0);
            checks++; if (bus.grant !== ((cyc % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_grant cyc %0d got %b want %b", cyc, bus.grant, (cyc % 2) ? 2'b10 : 2'b01); end
            checks++; if (bus.ch_response !== ((cyc % 2) ? 8'h60 : 8'h05)) begin errors++; $display("FAIL alt_response cyc %0d got %h want %h", cyc, bus.ch_response, (cyc % 2) ? 8'h60 : 8'h05); end
            tick();
        end
    endtask

    task automatic test_tag_return();
        do_reset();
        drive(2'd0, 2'd1, 4'd3, 4'd0, 64'd0);
        checks++; if (bus.grant !== 2'b10 || bus.proc2mem_addr !== 64'h1000 || bus.proc2mem_command !== 2'd1) begin errors++; $display("FAIL ret_issue got %b/%h/%0d want 10/1000/1", bus.grant, bus.proc2mem_addr, bus.proc2mem_command); end
        tick();
        for (int i = 0; i < 3; i++) begin drive(2'd0, 2'd0, 4'd0, 4'd0, 64'd0); tick(); end
        drive(2'd0, 2'd0, 4'd0, 4'd3, 64'hDEAD);
        checks++; if (bus.ch_tag_valid !== 2'b10) begin errors++; $display("FAIL ret_tag_valid got %b want 10", bus.ch_tag_valid); end
        checks++; if (bus.ch_tag !== 4'd3 || bus.ch_data !== 64'hDEAD) begin errors++; $display("FAIL ret_tag_data got %0d/%h want 3/dead", bus.ch_tag, bus.ch_data); end
        tick();
        drive(2'd0, 2'd0, 4'd0, 4'd3, 64'hBEEF);
        checks++; if (bus.ch_tag_valid !== 2'b00) begin errors++; $display("FAIL ret_cleared got %b want 00", bus.ch_tag_valid); end
        tick();
        drive(2'd0, 2'd0, 4'd0, 4'd0, 64'd0);
        checks++; if (bus.orphan_err !== 1'b1) begin errors++; $display("FAIL ret_second_orphan got %b want 1", bus.orphan_err); end
    endtask

    task automatic test_retry();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(2'd1, 2'd2, (i == 3) ? 4'd7 : 4'd0, 4'd0, 64'd0);
            checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL retry_grant cyc %0d got %b want 01", i, bus.grant); end
            tick();
        end
        drive(2'd1, 2'd2, 4'd0, 4'd0, 64'd0);
        checks++; if (bus.grant !== 2'b10) begin errors++; $display("FAIL retry_rr_advance got %b want 10", bus.grant); end
        tick();
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive(2'd1, 2'd0, 4'd4, 4'd0, 64'd0);
        checks++; if (bus.grant !== 2'b01) begin errors++; $display("FAIL same_alloc0 got %b want 01", bus.grant); end
        tick();
        drive(2'd0, 2'd1, 4'd4, 4'd4, 64'h44);
        checks++; if (bus.grant !== 2'b10 || bus.ch_tag_valid !== 2'b01) begin errors++; $display("FAIL same_route_old got %b/%b want 10/01", bus.grant, bus.ch_tag_valid); end
        tick();
        drive(2'd0, 2'd0, 4'd0, 4'd0, 64'd0);
        tick();
        drive(2'd0, 2'd0, 4'd0, 4'd4, 64'h45);
        checks++; if (bus.ch_tag_valid !== 2'b10) begin errors++; $display("FAIL same_route_new got %b want 10", bus.ch_tag_valid); end
        tick();
        drive(2'd0, 2'd0, 4'd0, 4'd0, 64'd0);
        checks++; if (bus.dup_err !== 1'b0 || bus.orphan_err !== 1'b0) begin errors++; $display("FAIL same_errs got %b%b want 00", bus.dup_err, bus.orphan_err); end
        tick();
    endtask

    task automatic test_orphan();
        do_reset();
        drive(2'd0, 2'd0, 4'd0, 4'd9, 64'h9);
        checks++; if (bus.ch_tag_valid !== 2'b00 || bus.orphan_err !== 1'b0) begin errors++; $display("FAIL orphan_cycle got %b/%b want 00/0", bus.ch_tag_valid, bus.orphan_err); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(2'd0, 2'd0, 4'd0, 4'd0, 64'd0);
            checks++; if (bus.orphan_err !== 1'b1) begin errors++; $display("FAIL orphan_sticky cyc %0d got %b want 1", i, bus.orphan_err); end
            tick();
        end
        do_reset();
        drive(2'd0, 2'd0, 4'd0, 4'd0, 64'd0);
        checks++; if (bus.orphan_err !== 1'b0) begin errors++; $display("FAIL orphan_cleared got %b want 0", bus.orphan_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(2'd2, 2'd0, 4'd2, 4'd0, 64'd0);
        tick();
        drive(2'd1, 2'd0, 4'd2, 4'd0, 64'd0);
        tick();
        reset = 1'b1;
        drive(2'd1, 2'd1, 4'd5, 4'd0, 64'd0);
        checks++; if (bus.grant !== 2'b00 || bus.ch_response !== 8'h00 || bus.proc2mem_command !== 2'd0) begin errors++; $display("FAIL mid_rst_outputs got %b/%h/%0d want 00/00/0", bus.grant, bus.ch_response, bus.proc2mem_command); end
        checks++; if (bus.proc2mem_addr !== 64'd0 || bus.proc2mem_data !== 64'd0) begin errors++; $display("FAIL mid_rst_bus got %h/%h want 0/0", bus.proc2mem_addr, bus.proc2mem_data); end
        tick();
        reset = 1'b0;
        drive(2'd1, 2'd1, 4'd0, 4'd2, 64'd0);
        checks++; if (bus.grant !== 2'b01 || bus.ch_tag_valid !== 2'b00) begin errors++; $display("FAIL mid_after got %b/%b want 01/00", bus.grant, bus.ch_tag_valid); end
        tick();
        drive(2'd0, 2'd0, 4'd0, 4'd0, 64'd0);
        checks++; if (bus.orphan_err !== 1'b1) begin errors++; $display("FAIL mid_orphan got %b want 1", bus.orphan_err); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [TAG_W-1:0] tag;
            int live [$];
            reset = ($urandom_range(0, 99) < 3);
            foreach (m_own[t]) if (m_own[t] >= 0) live.push_back(t);
            if (live.size() > 0 && $urandom_range(0, 9) < 4) tag = TAG_W'(live[$urandom_range(0, live.size() - 1)]);
            else if ($urandom_range(0, 9) < 5)               tag = '0;
            else                                             tag = TAG_W'($urandom_range(0, NUM_TAGS - 1));
            bus.req_cmd           = NUM_CH*2'($urandom);
            bus.req_addr          = {$urandom, $urandom, $urandom, $urandom};
            bus.req_data          = {$urandom, $urandom, $urandom, $urandom};
            bus.mem2proc_response = ($urandom_range(0, 3) == 0) ? 4'd0 : TAG_W'($urandom_range(0, NUM_TAGS - 1));
            bus.mem2proc_tag      = tag;
            bus.mem2proc_data     = {$urandom, $urandom};
            #1;
            model_eval();
            checks++; if (bus.grant !== e_grant) begin errors++; $display("FAIL rnd_grant n %0d got %b want %b", n, bus.grant, e_grant); end
            checks++; if (bus.ch_response !== e_resp) begin errors++; $display("FAIL rnd_response n %0d got %h want %h", n, bus.ch_response, e_resp); end
            checks++; if (bus.ch_tag_valid !== e_tv) begin errors++; $display("FAIL rnd_tag_valid n %0d got %b want %b", n, bus.ch_tag_valid, e_tv); end
            checks++; if (bus.ch_tag !== tag || bus.ch_data !== bus.mem2proc_data) begin errors++; $display("FAIL rnd_broadcast n %0d got %h/%h want %h/%h", n, bus.ch_tag, bus.ch_data, tag, bus.mem2proc_data); end
            checks++; if (bus.proc2mem_command !== e_cmd || bus.proc2mem_addr !== e_addr || bus.proc2mem_data !== e_data) begin errors++; $display("FAIL rnd_bus n %0d got %0d/%h/%h want %0d/%h/%h", n, bus.proc2mem_command, bus.proc2mem_addr, bus.proc2mem_data, e_cmd, e_addr, e_data); end
            checks++; if (bus.orphan_err !== m_orphan || bus.dup_err !== m_dup) begin errors++; $display("FAIL rnd_errs n %0d got %b%b want %b%b", n, bus.orphan_err, bus.dup_err, m_orphan, m_dup); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(2'd0, 2'd0, 4'd0, 4'd0, 64'd0);
        test_reset();
        test_alternate();
        test_tag_return();
        test_retry();
        test_same_cycle();
        test_orphan();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
